// File: rtl/serial_adder_param.sv
// Digit-serial adder: adds WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB first.
// Optional two's-complement overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_param: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_run;
  logic [DIGIT:0]   w_slice;
  logic [WIDTH-1:0] w_res_next;

  assign w_load  = start && (r_state != RUN);
  assign w_run   = (r_state == RUN);
  assign w_slice = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]} + (DIGIT+1)'(r_carry);

  // The newest digit enters at the top; only the older digits need storage.
  generate
    if (WIDTH > DIGIT) begin : g_shift
      logic [WIDTH-DIGIT-1:0] r_res_sh;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_res_sh <= '0;
        end else if (w_load) begin
          r_res_sh <= '0;
        end else if (w_run) begin
          r_res_sh <= w_res_next[WIDTH-1:DIGIT];
        end
      end

      assign w_res_next = {w_slice[DIGIT-1:0], r_res_sh};
    end else begin : g_single
      assign w_res_next = w_slice[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> DIGIT;
          r_b_sh  <= r_b_sh >> DIGIT;
          r_carry <= w_slice[DIGIT];
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            r_sum   <= w_res_next;
            r_cout  <= w_slice[DIGIT];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign bits are shifted away during RUN, so keep a copy from load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_run && r_count == LAST) begin
      r_ovf <= (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
